// File: rtl/valet_dispatch_ctrl.sv
// Round-robin park/retrieve sequencer in front of cam_lot: lookup, then write/read.
// Latency: DUP/FULL/MISS response 2 cycles after accept, OK 3 cycles after accept.
// Backpressure: resp_ready low holds RESP with stable fields and blocks new grants.
module valet_dispatch_ctrl #(
  parameter int  TAG_WIDTH = 16,
  parameter int  DEPTH     = 8,
  parameter int  NUM_REQ   = 4,
  localparam int IDX_W     = $clog2(DEPTH),
  localparam int CNT_W     = $clog2(DEPTH + 1),
  localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_op,
  input  logic [NUM_REQ*TAG_WIDTH-1:0] req_tag,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [ID_W-1:0]              resp_id,
  output logic [1:0]                   resp_status,
  output logic [TAG_WIDTH-1:0]         resp_tag,
  output logic [IDX_W-1:0]             resp_index,
  output logic                         cam_write_en,
  output logic                         cam_read_en,
  output logic [TAG_WIDTH-1:0]         cam_tag,
  input  logic                         cam_match,
  input  logic [IDX_W-1:0]             cam_index,
  input  logic [TAG_WIDTH-1:0]         cam_tag_out,
  output logic [CNT_W-1:0]             occupancy,
  output logic                         lot_full
);

  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_DUP  = 2'b01;
  localparam logic [1:0] ST_FULL = 2'b10;
  localparam logic [1:0] ST_MISS = 2'b11;

  typedef enum logic [1:0] {IDLE, LOOKUP, ACT, RESP} state_t;

  state_t               state, state_nxt;
  logic [ID_W-1:0]      rr_ptr;
  logic                 lat_op;
  logic [TAG_WIDTH-1:0] lat_tag;
  logic [ID_W-1:0]      lat_id;
  logic                 grant_vld;
  logic [ID_W-1:0]      grant_id;
  logic [ID_W-1:0]      cand;
  int                   idx;
  logic [TAG_WIDTH-1:0] tag_arr [NUM_REQ];

  assign resp_valid = (state == RESP);
  assign lot_full   = (occupancy == CNT_W'(DEPTH));

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      tag_arr[i] = req_tag[i*TAG_WIDTH +: TAG_WIDTH];
    end
  end

  // Walk downward so the candidate closest to rr_ptr is the last (winning) assignment.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    idx       = 0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = ID_W'(idx);
      if (req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_id  = cand;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    req_ready    = '0;
    cam_write_en = 1'b0;
    cam_read_en  = 1'b0;
    cam_tag      = '0;
    case (state)
      IDLE: begin
        if (grant_vld) begin
          req_ready[grant_id] = 1'b1;
          state_nxt           = LOOKUP;
        end
      end
      LOOKUP: begin
        cam_tag = lat_tag;
        if (!lat_op) state_nxt = (cam_match || lot_full) ? RESP : ACT;
        else         state_nxt = cam_match ? ACT : RESP;
      end
      ACT: begin
        cam_tag      = lat_tag;
        cam_write_en = !lat_op;
        cam_read_en  = lat_op;
        state_nxt    = RESP;
      end
      RESP: begin
        cam_tag = lat_tag;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      lat_op      <= 1'b0;
      lat_tag     <= '0;
      lat_id      <= '0;
      occupancy   <= '0;
      resp_id     <= '0;
      resp_status <= ST_OK;
      resp_tag    <= '0;
      resp_index  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (grant_vld) begin
            lat_op  <= req_op[grant_id];
            lat_tag <= tag_arr[grant_id];
            lat_id  <= grant_id;
            if (int'(grant_id) == NUM_REQ - 1) rr_ptr <= '0;
            else                               rr_ptr <= grant_id + 1'b1;
          end
        end
        LOOKUP: begin
          resp_id     <= lat_id;
          resp_tag    <= lat_tag;
          resp_index  <= '0;
          resp_status <= ST_OK;
          if (!lat_op) begin
            if (cam_match) begin
              resp_status <= ST_DUP;
              resp_index  <= cam_index;
            end else if (lot_full) begin
              resp_status <= ST_FULL;
            end
          end else if (!cam_match) begin
            resp_status <= ST_MISS;
          end
        end
        ACT: begin
          resp_status <= ST_OK;
          if (lat_op) begin
            resp_tag   <= cam_tag_out;
            resp_index <= cam_index;
            if (occupancy != '0) occupancy <= occupancy - 1'b1;
          end else if (!lot_full) begin
            occupancy <= occupancy + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // The lookup step filters out full-lot parks and missing retrieves, so ACT never saturates.
  always_ff @(posedge clk) begin
    if (rst_n && state == ACT) begin
      assert (lat_op ? (occupancy != '0) : !lot_full);
    end
  end

endmodule
